wb_regfile: RTL and testbench

//  Writeback stage plus architectural register file; consumes the MEM/WB pipeline register outputs.

---
 rtl/wb_regfile_pkg.sv | 24 ++
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile_load_formatter.sv | 40 ++++
 rtl/wb_regfile.sv | 67 ++++++
 tb/tb_wb_regfile.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback stage / register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int CNT_W  = 64;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, ID read ports and writeback/instret outputs bundled together.
// Latency: n/a (wires only).
// Backpressure: none; the writeback stage always accepts its slot.
// Ports: slave = register file side, master = pipeline/testbench side.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic              wb_valid;
  logic              wb_reg_write;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_funct3;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_alu;
  logic [XLEN-1:0]   wb_mem_data;
  logic [XLEN-1:0]   wb_pc4;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   wb_value;
  logic [CNT_W-1:0]  instret;

  modport slave (
    input  wb_valid, wb_reg_write, wb_sel, wb_funct3, wb_rd,
           wb_alu, wb_mem_data, wb_pc4, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_value, instret
  );

  modport master (
    output wb_valid, wb_reg_write, wb_sel, wb_funct3, wb_rd,
           wb_alu, wb_mem_data, wb_pc4, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_value, instret
  );

endinterface

// File: rtl/wb_regfile_load_formatter.sv
// Extracts and extends a byte/halfword/word from an aligned memory word.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (load kind), offset (address bits [1:0]), word (raw data), ld_fmt (result).
module wb_regfile_load_formatter
  import wb_regfile_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ld_fmt
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase

    // Halfword loads only look at offset[1]; a misaligned offset[0] is dropped.
    half_lane = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   ld_fmt = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  ld_fmt = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   ld_fmt = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  ld_fmt = {{(XLEN-16){1'b0}}, half_lane};
      F3_LW:   ld_fmt = word;
      default: ld_fmt = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback mux, x1..x31 register file with write-first bypass, instret counter.
// Latency: reads/wb_value combinational; register write and count take effect on the next edge.
// Backpressure: none; every valid slot retires in the cycle it arrives.
// Ports: clock, reset (async, active-high), bus (wb_regfile_if.slave).
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0]  ld_fmt;
  logic [XLEN-1:0]  wb_value;
  logic             we;
  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] instret_q;

  wb_regfile_load_formatter u_ld_fmt (
    .funct3 (bus.wb_funct3),
    .offset (bus.wb_alu[1:0]),
    .word   (bus.wb_mem_data),
    .ld_fmt (ld_fmt)
  );

  always_comb begin
    wb_value = '0;
    case (wb_sel_e'(bus.wb_sel))
      WB_ALU:  wb_value = bus.wb_alu;
      WB_LOAD: wb_value = ld_fmt;
      WB_PC4:  wb_value = bus.wb_pc4;
      WB_RSVD: wb_value = '0;
      default: wb_value = '0;
    endcase
  end

  // Gating with reset also kills the bypass while reset is held.
  assign we = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != '0) & ~reset;

  // regs[0] is cleared by reset and never written; reads of x0 are forced to 0 anyway.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      instret_q <= '0;
    end else begin
      if (we) begin
        regs[bus.wb_rd] <= wb_value;
      end
      if (bus.wb_valid) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign bus.rs1_data = (bus.rs1_addr == '0)                  ? '0       :
                        (we && (bus.rs1_addr == bus.wb_rd))   ? wb_value :
                                                                regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == '0)                  ? '0       :
                        (we && (bus.rs2_addr == bus.wb_rd))   ? wb_value :
                                                                regs[bus.rs2_addr];

  assign bus.wb_value = wb_value;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array/arithmetic reference model.
module tb_wb_regfile;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] mem);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((mem >> (8 * off)) & 32'hFF);
    h = 16'((mem >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return mem;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] mem,
                                         input logic [31:0] pc4);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ref_load(f3, alu[1:0], mem);
      2'd2:    return pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_we();
    return bus.wb_valid && bus.wb_reg_write && (bus.wb_rd != 0) && !reset;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (ref_we() && a == bus.wb_rd)
      return ref_wb(bus.wb_sel, bus.wb_funct3, bus.wb_alu, bus.wb_mem_data, bus.wb_pc4);
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instret = 64'd0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_wb(input logic v, input logic rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc4);
    bus.wb_valid     = v;
    bus.wb_reg_write = rw;
    bus.wb_sel       = sel;
    bus.wb_funct3    = f3;
    bus.wb_rd        = rd;
    bus.wb_alu       = alu;
    bus.wb_mem_data  = mem;
    bus.wb_pc4       = pc4;
  endtask

  task automatic idle();
    set_wb(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One rising edge; model updated with the inputs that were present at the edge.
  task automatic step();
    logic [31:0] v;
    logic        wr;
    v  = ref_wb(bus.wb_sel, bus.wb_funct3, bus.wb_alu, bus.wb_mem_data, bus.wb_pc4);
    wr = ref_we();
    @(posedge clock);
    if (!reset) begin
      if (bus.wb_valid) m_instret = m_instret + 64'd1;
      if (wr) m_regs[bus.wb_rd] = v;
    end
    @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd31;
    model_clear();
    @(negedge clock);
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rs1: got %h want %h", bus.rs1_data, 32'd0);
    end
    vectors++;
    if (bus.instret !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_instret: got %h want %h", bus.instret, 64'd0);
    end
    reset = 1'b0;
    set_wb(1'b1, 1'b1, 2'd0, 3'd0, 5'd5, 32'h1234, 32'd0, 32'd0);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'h1234) begin
      miscompares++;
      $display("FAIL reset_prewrite_x5: got %h want %h", bus.rs1_data, 32'h1234);
    end
    #1 reset = 1'b1;
    model_clear();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_midcycle_x5: got %h want %h", bus.rs1_data, 32'd0);
    end
    vectors++;
    if (bus.instret !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_midcycle_instret: got %h want %h", bus.instret, 64'd0);
    end
    // A write presented while reset is held must be neither bypassed nor stored.
    set_wb(1'b1, 1'b1, 2'd0, 3'd0, 5'd5, 32'h9999_0000, 32'd0, 32'd0);
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_no_bypass: got %h want %h", bus.rs1_data, 32'd0);
    end
    step();
    idle();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0 || bus.instret !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_write_lost: got %h/%h want 0/0", bus.rs1_data, bus.instret);
    end
  endtask

  task automatic test_x0();
    set_wb(1'b1, 1'b1, 2'd0, 3'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_same_cycle: got %h/%h want 0/0", bus.rs1_data, bus.rs2_data);
    end
    step();
    idle();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_next_cycle: got %h want %h", bus.rs1_data, 32'd0);
    end
  endtask

  task automatic test_bypass();
    set_wb(1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'hCAFE0001, 32'd0, 32'd0);
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    #1;
    vectors++;
    if (bus.rs1_data !== 32'hCAFE0001 || bus.rs2_data !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL bypass_both: got %h/%h want %h", bus.rs1_data, bus.rs2_data, 32'hCAFE0001);
    end
    step();
    idle();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h want %h", bus.rs1_data, 32'hCAFE0001);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [12] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010,
                              3'b001, 3'b101, 3'b011, 3'b100, 3'b000, 3'b001};
    logic [1:0]  off [12] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1,
                              2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] exp [12] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                              32'h00000001, 32'h80FF7F01, 32'hFFFF80FF, 32'h000080FF,
                              32'h80FF7F01, 32'h0000007F, 32'hFFFFFFFF, 32'h00007F01};
    logic [31:0] alu;
    logic [4:0]  rd;
    for (int i = 0; i < 12; i++) begin
      alu = ($urandom() & 32'hFFFF_FFFC) | 32'(off[i]);
      rd  = 5'(10 + i);
      set_wb(1'b1, 1'b1, 2'd1, f3[i], rd, alu, 32'h80FF7F01, 32'd0);
      bus.rs1_addr = rd;
      #1;
      vectors++;
      if (bus.wb_value !== exp[i] || bus.rs1_data !== exp[i]) begin
        miscompares++;
        $display("FAIL load_%0d f3=%b off=%0d: got %h/%h want %h",
                 i, f3[i], off[i], bus.wb_value, bus.rs1_data, exp[i]);
      end
      step();
      idle();
      bus.rs2_addr = rd;
      #1;
      vectors++;
      if (bus.rs2_data !== exp[i]) begin
        miscompares++;
        $display("FAIL load_stored_%0d: got %h want %h", i, bus.rs2_data, exp[i]);
      end
    end
  endtask

  task automatic test_mux_bubble();
    logic [63:0] cnt;
    set_wb(1'b1, 1'b1, 2'd2, 3'd0, 5'd3, 32'h5555_0000, 32'h1111_1111, 32'h104);
    step();
    idle();
    bus.rs1_addr = 5'd3;
    #1;
    vectors++;
    if (bus.rs1_data !== 32'h104) begin
      miscompares++;
      $display("FAIL mux_pc4: got %h want %h", bus.rs1_data, 32'h104);
    end
    set_wb(1'b1, 1'b1, 2'd3, 3'd0, 5'd3, 32'h5555_0000, 32'h1111_1111, 32'h104);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mux_rsvd: got %h want %h", bus.rs1_data, 32'd0);
    end
    cnt = m_instret;
    set_wb(1'b0, 1'b1, 2'd0, 3'd0, 5'd3, 32'h0000_0055, 32'd0, 32'd0);
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0) begin
      miscompares++;
      $display("FAIL bubble_bypass: got %h want %h", bus.rs1_data, 32'd0);
    end
    step();
    idle();
    #1;
    vectors++;
    if (bus.rs1_data !== 32'd0 || bus.instret !== cnt) begin
      miscompares++;
      $display("FAIL bubble: got %h/%0d want 0/%0d", bus.rs1_data, bus.instret, cnt);
    end
  endtask

  task automatic test_counter();
    reset = 1'b1;
    model_clear();
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_wb(1'b1, (i % 3 == 2) ? 1'b0 : 1'b1, 2'd0, 3'd0, 5'(20 + i), 32'(i), 32'd0, 32'd0);
      step();
    end
    idle();
    #1;
    vectors++;
    if (bus.instret !== 64'd10) begin
      miscompares++;
      $display("FAIL counter_ten: got %0d want %0d", bus.instret, 10);
    end
    force dut.instret_q = {64{1'b1}};
    #1 release dut.instret_q;
    m_instret = {64{1'b1}};
    #1;
    vectors++;
    if (bus.instret !== {64{1'b1}}) begin
      miscompares++;
      $display("FAIL counter_preload: got %h want all-ones", bus.instret);
    end
    set_wb(1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    step();
    idle();
    #1;
    vectors++;
    if (bus.instret !== 64'd0) begin
      miscompares++;
      $display("FAIL counter_wrap: got %h want %h", bus.instret, 64'd0);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ev;
    for (int n = 0; n < 400; n++) begin
      set_wb(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             $urandom(), $urandom(), $urandom());
      bus.rs1_addr = ($urandom_range(0, 3) == 0) ? bus.wb_rd : 5'($urandom_range(0, 31));
      bus.rs2_addr = ($urandom_range(0, 3) == 0) ? bus.wb_rd : 5'($urandom_range(0, 31));
      #1;
      e1 = ref_read(bus.rs1_addr);
      e2 = ref_read(bus.rs2_addr);
      ev = ref_wb(bus.wb_sel, bus.wb_funct3, bus.wb_alu, bus.wb_mem_data, bus.wb_pc4);
      vectors++;
      if (bus.rs1_data !== e1 || bus.rs2_data !== e2) begin
        miscompares++;
        $display("FAIL rand_read_%0d: got %h/%h want %h/%h", n, bus.rs1_data, bus.rs2_data, e1, e2);
      end
      vectors++;
      if (bus.wb_value !== ev || bus.instret !== m_instret) begin
        miscompares++;
        $display("FAIL rand_wb_%0d: got %h/%0d want %h/%0d", n, bus.wb_value, bus.instret, ev, m_instret);
      end
      step();
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_x0();
    test_bypass();
    test_loads();
    test_mux_bubble();
    test_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
